// File: rtl/fw_interface_arb.sv
`default_nettype none
// ============================================================================
// Module      : fw_interface_arb
// Description : Two-master round-robin Wishbone arbiter with no-response watchdog
// Revision    : 1.0 - initial release
// ============================================================================
module fw_interface_arb #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  localparam bit                  C_TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_WIDTH-1:0] C_TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_last_grant;
  logic                w_last_grant_next;
  logic [TO_WIDTH-1:0] r_to_cnt;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_resp;
  logic                w_wait;
  logic                w_timeout;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  // Grants only leave IDLE, so there is always one idle turnaround cycle.
  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) w_state_next = r_last_grant ? ST_GNT0 : ST_GNT1;
        else if (m0_cyc_i)        w_state_next = ST_GNT0;
        else if (m1_cyc_i)        w_state_next = ST_GNT1;
      end
      ST_GNT0: begin
        if (!m0_cyc_i) begin
          w_state_next      = ST_IDLE;
          w_last_grant_next = 1'b0;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i) begin
          w_state_next      = ST_IDLE;
          w_last_grant_next = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_gnt0  = (r_state == ST_GNT0);
  assign w_gnt1  = (r_state == ST_GNT1);
  assign grant_o = {w_gnt1, w_gnt0};

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (w_gnt0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cti_o = m0_cti_i;
      s_bte_o = m0_bte_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
    end else if (w_gnt1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cti_o = m1_cti_i;
      s_bte_o = m1_bte_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
    end
  end

  assign w_resp    = s_ack_i | s_err_i | s_rty_i;
  assign w_wait    = s_cyc_o & s_stb_o & ~w_resp;
  assign w_timeout = C_TO_EN && w_wait && (r_to_cnt == C_TO_LAST);
  assign timeout_o = w_timeout;

  // Counter value equals the number of earlier unanswered strobe cycles.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !C_TO_EN) begin
      r_to_cnt <= '0;
    end else if (!w_wait || w_timeout || (w_state_next != r_state)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign m0_dat_o = w_gnt0 ? s_dat_i : '0;
  assign m0_ack_o = w_gnt0 & s_ack_i;
  assign m0_err_o = w_gnt0 & (s_err_i | w_timeout);
  assign m0_rty_o = w_gnt0 & s_rty_i;
  assign m1_dat_o = w_gnt1 ? s_dat_i : '0;
  assign m1_ack_o = w_gnt1 & s_ack_i;
  assign m1_err_o = w_gnt1 & (s_err_i | w_timeout);
  assign m1_rty_o = w_gnt1 & s_rty_i;

endmodule
`default_nettype wire

// File: tb/tb_fw_interface_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fw_interface_arb
// Description : Directed self-checking bench for fw_interface_arb
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fw_interface_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat_i;
  logic [3:0]  m0_sel, m1_sel;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
  logic        s_ack_i, s_err_i, s_rty_i;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, timeout_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o, grant_o;

  logic [31:0] n_m0_dat_o, n_m1_dat_o, n_s_adr_o, n_s_dat_o;
  logic        n_m0_ack_o, n_m0_err_o, n_m0_rty_o, n_m1_ack_o, n_m1_err_o, n_m1_rty_o;
  logic [3:0]  n_s_sel_o;
  logic        n_s_we_o, n_s_cyc_o, n_s_stb_o, n_timeout_o;
  logic [2:0]  n_s_cti_o;
  logic [1:0]  n_s_bte_o, n_grant_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fw_interface_arb #(.TIMEOUT_CYCLES(16), .TO_WIDTH(8)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cti_i(m0_cti), .m0_bte_i(m0_bte), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cti_i(m1_cti), .m1_bte_i(m1_bte), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  // Same stimulus, watchdog disabled.
  fw_interface_arb #(.TIMEOUT_CYCLES(0), .TO_WIDTH(8)) u_dut_nt (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cti_i(m0_cti), .m0_bte_i(m0_bte), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
    .m0_dat_o(n_m0_dat_o), .m0_ack_o(n_m0_ack_o), .m0_err_o(n_m0_err_o), .m0_rty_o(n_m0_rty_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cti_i(m1_cti), .m1_bte_i(m1_bte), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
    .m1_dat_o(n_m1_dat_o), .m1_ack_o(n_m1_ack_o), .m1_err_o(n_m1_err_o), .m1_rty_o(n_m1_rty_o),
    .s_adr_o(n_s_adr_o), .s_dat_o(n_s_dat_o), .s_sel_o(n_s_sel_o), .s_we_o(n_s_we_o),
    .s_cti_o(n_s_cti_o), .s_bte_o(n_s_bte_o), .s_cyc_o(n_s_cyc_o), .s_stb_o(n_s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(n_grant_o), .timeout_o(n_timeout_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 0; m0_cti = '0; m0_bte = '0;
    m0_cyc = 0; m0_stb = 0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 0; m1_cti = '0; m1_bte = '0;
    m1_cyc = 0; m1_stb = 0;
    s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (3) tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    s_dat_i = 32'hA5A5_5A5A; s_ack_i = 1; s_err_i = 1; s_rty_i = 1;
    repeat (3) tick();
    #1;
    checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant_o); end
    checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_adr_o !== 32'h0) begin
      failures++; $display("FAIL reset_s_bus cyc=%b stb=%b adr=%h exp=0", s_cyc_o, s_stb_o, s_adr_o); end
    checks++; if ({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o} !== 6'b0) begin
      failures++; $display("FAIL reset_resp got=%b%b%b%b%b%b exp=000000",
        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o); end
    checks++; if (m0_dat_o !== 32'h0 || m1_dat_o !== 32'h0 || timeout_o !== 1'b0) begin
      failures++; $display("FAIL reset_dat m0=%h m1=%h to=%b exp=0", m0_dat_o, m1_dat_o, timeout_o); end
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_single_write();
    m0_adr = 32'h0000_0004; m0_dat = 32'hDEAD_BEEF; m0_sel = 4'hF; m0_we = 1;
    m0_cyc = 1; m0_stb = 1;
    #1;
    checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL wr_pre_grant got=%b exp=00", grant_o); end
    tick();
    checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL wr_grant got=%b exp=01", grant_o); end
    checks++; if (s_adr_o !== 32'h4 || s_dat_o !== 32'hDEAD_BEEF || s_sel_o !== 4'hF || s_we_o !== 1'b1) begin
      failures++; $display("FAIL wr_slave_bus adr=%h dat=%h sel=%h we=%b exp=4/deadbeef/f/1",
        s_adr_o, s_dat_o, s_sel_o, s_we_o); end
    s_ack_i = 1; s_dat_i = 32'h1234_5678;
    #1;
    checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
      failures++; $display("FAIL wr_ack_route m0=%b m1=%b exp=1/0", m0_ack_o, m1_ack_o); end
    checks++; if (m0_dat_o !== 32'h1234_5678 || m1_dat_o !== 32'h0) begin
      failures++; $display("FAIL wr_dat_route m0=%h m1=%h exp=12345678/0", m0_dat_o, m1_dat_o); end
    tick();
    idle_inputs();
    tick();
    checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL wr_release got=%b exp=00", grant_o); end
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    tick();
    checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL rr_first got=%b exp=01", grant_o); end
    m0_cyc = 0;
    tick();
    checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL rr_turnaround got=%b exp=00", grant_o); end
    tick();
    checks++; if (grant_o !== 2'b10) begin failures++; $display("FAIL rr_second got=%b exp=10", grant_o); end
    m1_cyc = 0;
    tick();
    checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL rr_idle2 got=%b exp=00", grant_o); end
    m0_cyc = 1; m1_cyc = 1;
    tick();
    checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL rr_alternate got=%b exp=01", grant_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_burst();
    logic [2:0] cti_tab [4];
    cti_tab[0] = 3'b010; cti_tab[1] = 3'b010; cti_tab[2] = 3'b010; cti_tab[3] = 3'b111;
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h100; m1_cti = 3'b010; m1_bte = 2'b00;
    tick();
    m0_cyc = 1; m0_stb = 1;
    for (int b = 0; b < 4; b++) begin
      m1_adr = 32'h100 + 32'(b * 4); m1_cti = cti_tab[b];
      s_ack_i = 1; s_dat_i = 32'hB000 + 32'(b);
      #1;
      checks++; if (grant_o !== 2'b10 || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
        failures++; $display("FAIL burst_beat%0d grant=%b m1_ack=%b m0_ack=%b exp=10/1/0",
          b, grant_o, m1_ack_o, m0_ack_o); end
      checks++; if (s_adr_o !== 32'h100 + 32'(b * 4) || s_cti_o !== cti_tab[b] || m1_dat_o !== 32'hB000 + 32'(b)) begin
        failures++; $display("FAIL burst_bus%0d adr=%h cti=%b dat=%h", b, s_adr_o, s_cti_o, m1_dat_o); end
      tick();
    end
    m1_cyc = 0; m1_stb = 0; s_ack_i = 0;
    tick();
    checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL burst_gap got=%b exp=00", grant_o); end
    tick();
    checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL burst_m0_after got=%b exp=01", grant_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_watchdog();
    logic nt_seen;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h10;
    tick();
    for (int k = 1; k <= 16; k++) begin
      #1;
      checks++; if (m0_err_o !== (k == 16) || timeout_o !== (k == 16) || m1_err_o !== 1'b0) begin
        failures++; $display("FAIL wd_cycle%0d err=%b to=%b m1_err=%b exp=%0d", k, m0_err_o, timeout_o,
          m1_err_o, (k == 16)); end
      tick();
    end
    #1;
    checks++; if (m0_err_o !== 1'b0 || timeout_o !== 1'b0) begin
      failures++; $display("FAIL wd_after err=%b to=%b exp=0", m0_err_o, timeout_o); end
    nt_seen = 0;
    for (int k = 0; k < 1000; k++) begin
      if (n_m0_err_o !== 1'b0 || n_timeout_o !== 1'b0) nt_seen = 1;
      tick();
    end
    checks++; if (nt_seen !== 1'b0) begin failures++; $display("FAIL wd_disabled got=1 exp=0"); end
    s_err_i = 1;
    #1;
    checks++; if (m0_err_o !== 1'b1 || n_m0_err_o !== 1'b1) begin
      failures++; $display("FAIL wd_slave_err got=%b/%b exp=1/1", m0_err_o, n_m0_err_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_cti = 3'b010;
    tick();
    s_ack_i = 1;
    tick();
    s_ack_i = 0; m0_cyc = 1; m0_stb = 1; rst = 1;
    tick();
    checks++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0 || m1_ack_o !== 1'b0) begin
      failures++; $display("FAIL rstmid_state grant=%b cyc=%b ack=%b exp=00/0/0", grant_o, s_cyc_o, m1_ack_o); end
    checks++; if (u_dut.r_to_cnt !== 8'd0) begin
      failures++; $display("FAIL rstmid_counter got=%0d exp=0", u_dut.r_to_cnt); end
    rst = 0;
    tick();
    checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL rstmid_m0_first got=%b exp=01", grant_o); end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_burst();
    test_watchdog();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
